// File: rtl/pow_n_iterative.sv
// Runtime-exponent power unit: n^exp mod 2^WIDTH by right-to-left square-and-multiply,
// with a fixed EXP_WIDTH-cycle compute phase, valid/ready on both sides and a sticky overflow flag.
module pow_n_iterative #(
    parameter int WIDTH     = 18,
    parameter int EXP_WIDTH = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     n,
    input  logic [EXP_WIDTH-1:0] exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     n_pow,
    output logic                 overflow,
    output logic                 busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CNT_WIDTH = $clog2(EXP_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(EXP_WIDTH - 1);

    logic [1:0]           state;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     base;
    logic [EXP_WIDTH-1:0] e;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 ovf;

    logic [2*WIDTH-1:0]   prod_acc;
    logic [2*WIDTH-1:0]   prod_sq;
    logic                 more_bits;
    logic                 step_ovf;

    // A squaring only matters if a higher exponent bit will consume it.
    always_comb begin
        prod_acc  = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, base};
        prod_sq   = {{WIDTH{1'b0}}, base} * {{WIDTH{1'b0}}, base};
        more_bits = (e >> 1) != '0;
        step_ovf  = (e[0] && (prod_acc[2*WIDTH-1:WIDTH] != '0))
                 || (more_bits && (prod_sq[2*WIDTH-1:WIDTH] != '0));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            acc   <= WIDTH'(1);
            base  <= '0;
            e     <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= WIDTH'(1);
                        base  <= n;
                        e     <= exp;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (e[0]) begin
                        acc <= prod_acc[WIDTH-1:0];
                    end
                    base <= prod_sq[WIDTH-1:0];
                    e    <= e >> 1;
                    cnt  <= cnt + 1'b1;
                    ovf  <= ovf | step_ovf;
                    // Always run every step so latency never depends on the exponent.
                    if (cnt == LAST_STEP) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign n_pow     = acc;
    assign overflow  = ovf;

endmodule

// File: tb/tb_pow_n_iterative.sv
// Self-checking bench for pow_n_iterative: directed vector table, multi-cycle corner
// sequences and randomized operations checked against an exact-arithmetic power model.
module tb_pow_n_iterative;

    localparam int W  = 18;
    localparam int EW = 3;

    logic          clock;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  n_in;
    logic [EW-1:0] exp_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  n_pow;
    logic          overflow;
    logic          busy;

    int compared;
    int mismatched;

    typedef struct {
        logic [W-1:0]  n;
        logic [EW-1:0] e;
        logic [W-1:0]  pow;
        logic          ovf;
        int            hold;
    } vec_t;

    vec_t vecs[7];

    pow_n_iterative #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n         (n_in),
        .exp       (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .n_pow     (n_pow),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Exact integer power; 7 * 18 bits fits comfortably in 128.
    function automatic logic [127:0] true_pow(input logic [W-1:0] b, input int e);
        logic [127:0] r;
        r = 128'd1;
        for (int i = 0; i < e; i++) begin
            r = r * {110'd0, b};
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    // One full operation: accept, fixed latency, optional backpressure, result handshake.
    task automatic apply_stimulus(input logic [W-1:0] nv, input logic [EW-1:0] ev,
                                  input logic [W-1:0] pow, input logic ovf, input int hold);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        check_output("in_ready_before_accept", 64'(in_ready), 64'd1);
        n_in     = nv;
        exp_in   = ev;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_in     = $urandom;
        exp_in   = EW'($urandom);
        lat = 0;
        while (!out_valid && lat < EW + 6) begin
            if (in_ready || !busy) begin
                check_output("busy_during_calc", 64'({in_ready, busy}), 64'b01);
            end
            step();
            lat++;
        end
        check_output("latency", 64'(lat), 64'(EW));
        if (!out_valid) begin
            do_reset();
            return;
        end
        for (int h = 0; h < hold; h++) begin
            check_output("hold_valid", 64'({out_valid, in_ready}), 64'b10);
            check_output("hold_pow", 64'(n_pow), 64'(pow));
            check_output("hold_ovf", 64'(overflow), 64'(ovf));
            step();
        end
        check_output("n_pow", 64'(n_pow), 64'(pow));
        check_output("overflow", 64'(overflow), 64'(ovf));
        check_output("out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_output("idle_after_handshake", 64'({in_ready, out_valid, busy}), 64'b100);
    endtask

    task automatic back_to_back(input int count);
        logic [W-1:0]  qn[$];
        logic [EW-1:0] qe[$];
        logic [W-1:0]  exp_pow[$];
        logic          exp_ovf[$];
        logic [127:0]  r;
        int cyc;
        int last_hs;
        int accepted;
        int results;
        logic pre_ready;
        logic acc_now;
        for (int i = 0; i < count; i++) begin
            qn.push_back(W'($urandom_range(0, 40)));
            qe.push_back(EW'($urandom));
        end
        cyc = 0;
        last_hs = 0;
        accepted = 0;
        results = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        n_in      = qn[0];
        exp_in    = qe[0];
        while (results < count && cyc < 200) begin
            pre_ready = in_ready;
            acc_now   = pre_ready && in_valid;
            if (out_valid) begin
                check_output("b2b_pow", 64'(n_pow), 64'(exp_pow.size() > 0 ? exp_pow[0] : '0));
                check_output("b2b_ovf", 64'(overflow), 64'(exp_ovf.size() > 0 ? exp_ovf[0] : 1'b0));
                if (exp_pow.size() > 0) begin
                    void'(exp_pow.pop_front());
                    void'(exp_ovf.pop_front());
                end
                last_hs = cyc + 1;
                results++;
            end
            step();
            cyc++;
            if (acc_now) begin
                if (accepted > 0) begin
                    check_output("b2b_accept_edge", 64'(cyc), 64'(last_hs + 1));
                end
                r = true_pow(qn[accepted], int'(qe[accepted]));
                exp_pow.push_back(r[W-1:0]);
                exp_ovf.push_back(r[127:W] != '0);
                accepted++;
                if (accepted < count) begin
                    n_in   = qn[accepted];
                    exp_in = qe[accepted];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_output("b2b_results", 64'(results), 64'(count));
        check_output("b2b_accepted", 64'(accepted), 64'(count));
        if (results != count) begin
            do_reset();
        end
    endtask

    initial begin
        logic [127:0] r;
        logic [W-1:0] rn;
        logic [EW-1:0] re;
        compared   = 0;
        mismatched = 0;
        n_in       = '0;
        exp_in     = '0;

        vecs[0] = '{n: 18'd3,      e: 3'd5, pow: 18'd243,   ovf: 1'b0, hold: 0};
        vecs[1] = '{n: 18'd7,      e: 3'd7, pow: 18'd37111, ovf: 1'b1, hold: 0};
        vecs[2] = '{n: 18'd262143, e: 3'd4, pow: 18'd1,     ovf: 1'b1, hold: 1};
        vecs[3] = '{n: 18'd512,    e: 3'd1, pow: 18'd512,   ovf: 1'b0, hold: 0};
        vecs[4] = '{n: 18'd0,      e: 3'd0, pow: 18'd1,     ovf: 1'b0, hold: 0};
        vecs[5] = '{n: 18'd5,      e: 3'd0, pow: 18'd1,     ovf: 1'b0, hold: 2};
        vecs[6] = '{n: 18'd2,      e: 3'd6, pow: 18'd64,    ovf: 1'b0, hold: 5};

        do_reset();
        check_output("reset_ctrl", 64'({in_ready, out_valid, busy}), 64'b100);
        check_output("reset_pow", 64'(n_pow), 64'd1);
        check_output("reset_ovf", 64'(overflow), 64'd0);

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i].n, vecs[i].e, vecs[i].pow, vecs[i].ovf, vecs[i].hold);
        end

        // Abort in the middle of CALC: the pending result must never appear.
        n_in     = 18'd3;
        exp_in   = 3'd7;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_output("abort_ctrl", 64'({in_ready, out_valid, busy}), 64'b100);
        check_output("abort_pow", 64'(n_pow), 64'd1);
        check_output("abort_ovf", 64'(overflow), 64'd0);
        apply_stimulus(18'd3, 3'd2, 18'd9, 1'b0, 0);

        back_to_back(4);

        for (int i = 0; i < 24; i++) begin
            rn = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            re = EW'($urandom);
            r  = true_pow(rn, int'(re));
            apply_stimulus(rn, re, r[W-1:0], r[127:W] != '0, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
